// File: rtl/md_issue_if.sv
// md_issue_if: E-stage/MDU issue interface.
// The master side is the E-stage plus MDU environment; the slave side is md_issue.
interface md_issue_if;
   logic        e_valid;
   logic [3:0]  e_op;
   logic [31:0] e_rs;
   logic [31:0] e_rt;
   logic        flush;
   logic        md_busy;
   logic        md_start;
   logic [3:0]  md_op;
   logic [31:0] md_d1;
   logic [31:0] md_d2;
   logic        stall_d;
   logic        hilo_done;
   logic        sync_err;

   modport master (
      output e_valid, e_op, e_rs, e_rt, flush, md_busy,
      input  md_start, md_op, md_d1, md_d2, stall_d, hilo_done, sync_err
   );

   modport slave (
      input  e_valid, e_op, e_rs, e_rt, flush, md_busy,
      output md_start, md_op, md_d1, md_d2, stall_d, hilo_done, sync_err
   );
endinterface

// File: rtl/md_issue.sv
// md_issue: E-stage issue controller for the multiply/divide unit.
// Registers an accepted op and its operands into a one-cycle start pulse,
// tracks the MDU's fixed latency with a local counter, and drives the D stall.
// Optional feature macro: MD_ISSUE_SKID_EN (one-entry skid register while busy).
module md_issue #(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10,
   parameter int CNT_W   = 4
) (
   input logic        clk,
   input logic        reset,
   md_issue_if.slave  bus
);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   localparam logic [CNT_W-1:0] MUL_CNT    = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] DIV_CNT    = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] MUL_CNT_M1 = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT_M1 = CNT_W'(DIV_LAT - 1);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_is_div, w_is_div_nxt;
   logic             w_done_nxt;

   logic             r_md_start;
   logic [3:0]       r_md_op;
   logic [31:0]      r_md_d1, r_md_d2;
   logic             r_hilo_done;
   logic             r_sync_err;

   logic             w_md_req, w_e_issuable, w_e_mf;
   logic             w_stall, w_issue;
   logic [3:0]       w_iss_op;
   logic [31:0]      w_iss_d1, w_iss_d2;
   logic [CNT_W-1:0] w_lat_m1;
   logic             w_sync_bad;

`ifdef MD_ISSUE_SKID_EN
   logic             r_skid_v;
   logic [3:0]       r_skid_op;
   logic [31:0]      r_skid_rs, r_skid_rt;
   logic             w_skid_load, w_skid_issue;
`endif

   // Request decode, stall and issue selection.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      w_e_issuable = bus.e_op inside {[4'd1:4'd6]};
      w_e_mf       = bus.e_op inside {4'd7, 4'd8};
      w_md_req     = bus.e_valid & ~bus.flush & (bus.e_op inside {[4'd1:4'd8]});
      w_iss_op     = bus.e_op;
      w_iss_d1     = bus.e_rs;
      w_iss_d2     = bus.e_rt;
`ifdef MD_ISSUE_SKID_EN
      // In BUSY only a full skid or an HI/LO read holds E; in IDLE a pending skid has priority.
      if (r_state == S_IDLE)
         w_stall = w_md_req & (r_md_start | bus.md_busy | r_skid_v);
      else
         w_stall = w_md_req & (r_skid_v | w_e_mf);
      w_skid_load  = (r_state == S_BUSY) & w_md_req & ~w_stall & w_e_issuable;
      w_skid_issue = (r_state == S_IDLE) & r_skid_v & ~r_md_start & ~bus.md_busy;
      w_issue      = w_skid_issue |
                     ((r_state == S_IDLE) & w_md_req & ~w_stall & w_e_issuable);
      if (w_skid_issue) begin
         w_iss_op = r_skid_op;
         w_iss_d1 = r_skid_rs;
         w_iss_d2 = r_skid_rt;
      end
`else
      w_stall = w_md_req & ((r_state != S_IDLE) | r_md_start | bus.md_busy);
      w_issue = (r_state == S_IDLE) & w_md_req & ~w_stall & w_e_issuable;
`endif
   end

   // FSM state register: phase, latency counter and op class of the running op.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_is_div <= w_is_div_nxt;
      end
   end

   // FSM next-state: load latency on an arithmetic issue, count down while busy.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_is_div_nxt = r_is_div;
      w_done_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_issue && (w_iss_op inside {[4'd1:4'd4]})) begin
               w_state_nxt  = S_BUSY;
               w_is_div_nxt = w_iss_op inside {4'd3, 4'd4};
               w_cnt_nxt    = w_is_div_nxt ? DIV_CNT : MUL_CNT;
            end
         end
         S_BUSY: begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: combinational stall and the MDU/counter consistency test.
   always_comb begin
      w_lat_m1   = r_is_div ? DIV_CNT_M1 : MUL_CNT_M1;
      w_sync_bad = ((r_state == S_BUSY) & (r_cnt < w_lat_m1) & ~bus.md_busy) |
                   ((r_state == S_IDLE) & ~r_md_start & bus.md_busy);
      bus.stall_d   = w_stall;
      bus.md_start  = r_md_start;
      bus.md_op     = r_md_op;
      bus.md_d1     = r_md_d1;
      bus.md_d2     = r_md_d2;
      bus.hilo_done = r_hilo_done;
      bus.sync_err  = r_sync_err;
   end

   // Issue registers: start pulse, op, operands, completion pulse and sticky error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_md_start  <= 1'b0;
         r_md_op     <= 4'd0;
         r_md_d1     <= 32'd0;
         r_md_d2     <= 32'd0;
         r_hilo_done <= 1'b0;
         r_sync_err  <= 1'b0;
      end else begin
         r_md_start  <= w_issue;
         r_md_op     <= w_issue ? w_iss_op : 4'd0;
         if (w_issue) begin
            r_md_d1 <= w_iss_d1;
            r_md_d2 <= w_iss_d2;
         end
         r_hilo_done <= w_done_nxt;
         if (w_sync_bad)
            r_sync_err <= 1'b1;
      end
   end

`ifdef MD_ISSUE_SKID_EN
   // Skid entry: captured while BUSY, released once back in IDLE; flush cannot drop it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the skid payload is reset too, so the issued operands are never X.
         r_skid_v  <= 1'b0;
         r_skid_op <= 4'd0;
         r_skid_rs <= 32'd0;
         r_skid_rt <= 32'd0;
      end else if (w_skid_load) begin
         r_skid_v  <= 1'b1;
         r_skid_op <= bus.e_op;
         r_skid_rs <= bus.e_rs;
         r_skid_rt <= bus.e_rt;
      end else if (w_skid_issue) begin
         r_skid_v  <= 1'b0;
      end
   end
`endif

endmodule
